neuron_train_ctrl: RTL and testbench

NEURON_TRAIN_CTRL -- requirements
Module: neuron_train_ctrl

---
 rtl/neuron_train_ctrl_pkg.sv | 35 +++
 rtl/train_err_acc.sv | 32 +++
 rtl/neuron_train_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_neuron_train_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_train_ctrl_pkg.sv
// Shared types for the neuron training controller: fixed-point sample type,
// error width, controller states and the absolute-difference helper.
package neuron_train_ctrl_pkg;

  localparam int Z2O_W = 16;
  localparam int ERR_W = 24;

  typedef logic [Z2O_W-1:0]        zero2one_t;
  typedef logic signed [Z2O_W:0]   frac_t;
  typedef logic [Z2O_W:0]          abs_diff_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEED      = 3'd1,
    ST_FETCH     = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_LEARN     = 3'd4,
    ST_EPOCH_END = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // One extra bit of headroom so the difference can never wrap.
  function automatic abs_diff_t abs_diff(input zero2one_t a, input zero2one_t b);
    abs_diff_t wa;
    abs_diff_t wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    if (wa >= wb) begin
      abs_diff = wa - wb;
    end else begin
      abs_diff = wb - wa;
    end
  endfunction

endpackage

// File: rtl/train_err_acc.sv
// Saturating accumulator of |expected - observed| over one training epoch.
module train_err_acc
  import neuron_train_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  zero2one_t        expected,
  input  zero2one_t        observed,
  output logic [ERR_W-1:0] acc
);

  logic [ERR_W:0] sum_s;

  // Widened sum; the carry bit flags saturation.
  always_comb begin
    sum_s = {1'b0, acc} + {{(ERR_W-Z2O_W){1'b0}}, abs_diff(expected, observed)};
  end

  // Accumulator register: clear wins over add.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= {ERR_W{1'b0}};
    end else if (clr) begin
      acc <= {ERR_W{1'b0}};
    end else if (add_en) begin
      acc <= sum_s[ERR_W] ? {ERR_W{1'b1}} : sum_s[ERR_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_train_ctrl.sv
// Sequences an external learning neuron: seeds weights, streams samples,
// accumulates per-epoch error and stops on convergence or epoch limit.
module neuron_train_ctrl
  import neuron_train_ctrl_pkg::*;
#(
  parameter int N             = 16,
  parameter int SEED_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_EPOCHS    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 learn_en,
  input  logic [ERR_W-1:0]     err_threshold,
  input  logic                 smp_valid,
  output logic                 smp_ready,
  input  zero2one_t [N-1:0]    smp_in,
  input  zero2one_t            smp_expected,
  input  logic                 smp_last,
  output logic                 nrn_trigger,
  output logic                 nrn_valid,
  output logic                 nrn_learn,
  output zero2one_t [N-1:0]    nrn_in,
  output zero2one_t            nrn_expected_out,
  input  zero2one_t            nrn_out,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [7:0]           epoch_count,
  output logic [ERR_W-1:0]     epoch_err
);

  localparam logic [15:0] SEED_LAST   = 16'(SEED_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  MAX_EP      = 8'(MAX_EPOCHS);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [15:0]      cnt_r;
  logic [15:0]      cnt_nxt_s;
  logic             last_r;
  logic             learn_phase_r;
  logic             latch_s;
  logic             acc_add_s;
  logic             acc_clr_s;
  logic             start_run_s;
  logic             epoch_end_s;
  logic             conv_hit_s;
  logic [7:0]       epoch_inc_s;
  logic [ERR_W-1:0] acc_s;

  train_err_acc u_err_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr_s),
    .add_en   (acc_add_s),
    .expected (nrn_expected_out),
    .observed (nrn_out),
    .acc      (acc_s)
  );

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    acc_add_s   = 1'b0;
    acc_clr_s   = 1'b0;
    start_run_s = 1'b0;
    epoch_end_s = 1'b0;
    conv_hit_s  = 1'b0;
    epoch_inc_s = epoch_count + 8'd1;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SEED;
          cnt_nxt_s   = 16'd0;
          start_run_s = 1'b1;
          acc_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEED: begin
        if (cnt_r == SEED_LAST) begin
          state_nxt_s = ST_FETCH;
          cnt_nxt_s   = 16'd0;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_FETCH: begin
        if (smp_valid) begin
          latch_s     = 1'b1;
          state_nxt_s = ST_SETTLE;
          cnt_nxt_s   = 16'd0;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          acc_add_s   = 1'b1;
          state_nxt_s = ST_LEARN;
          cnt_nxt_s   = 16'd0;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_LEARN: begin
        if (last_r) begin
          state_nxt_s = ST_EPOCH_END;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_EPOCH_END: begin
        epoch_end_s = 1'b1;
        acc_clr_s   = 1'b1;
        if (acc_s <= err_threshold) begin
          conv_hit_s  = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (epoch_inc_s == MAX_EP) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, sample hold and status registers; outputs follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      cnt_r            <= 16'd0;
      last_r           <= 1'b0;
      learn_phase_r    <= 1'b0;
      smp_ready        <= 1'b0;
      nrn_trigger      <= 1'b0;
      nrn_valid        <= 1'b0;
      nrn_in           <= '0;
      nrn_expected_out <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      converged        <= 1'b0;
      epoch_count      <= 8'd0;
      epoch_err        <= {ERR_W{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      smp_ready     <= (state_nxt_s == ST_FETCH);
      nrn_trigger   <= (state_nxt_s == ST_SEED) || (state_nxt_s == ST_LEARN);
      nrn_valid     <= (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_LEARN);
      learn_phase_r <= (state_nxt_s == ST_LEARN);
      busy          <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
      done          <= (state_nxt_s == ST_DONE);
      if (latch_s) begin
        nrn_in           <= smp_in;
        nrn_expected_out <= smp_expected;
        last_r           <= smp_last;
      end
      if (start_run_s) begin
        epoch_count <= 8'd0;
        converged   <= 1'b0;
      end else if (epoch_end_s) begin
        epoch_count <= epoch_inc_s;
        epoch_err   <= acc_s;
        if (conv_hit_s) begin
          converged <= 1'b1;
        end
      end
    end
  end

  // learn_en is taken live during the LEARN cycle itself.
  assign nrn_learn = learn_phase_r & learn_en;

endmodule

// File: tb/tb_neuron_train_ctrl.sv
// Scoreboard bench for neuron_train_ctrl: the bench plays the neuron and the
// sample source; expected epoch results are queued as samples are driven.
module tb_neuron_train_ctrl;
  import neuron_train_ctrl_pkg::*;

  localparam int N = 4;

  typedef struct {
    logic [7:0]       cnt;
    logic [ERR_W-1:0] err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, start, learn_en, smp_valid, smp_ready, smp_last;
  logic [ERR_W-1:0] err_threshold;
  zero2one_t [N-1:0] smp_in, nrn_in;
  zero2one_t        smp_expected, nrn_expected_out, nrn_out;
  logic             nrn_trigger, nrn_valid, nrn_learn, busy, done, converged;
  logic [7:0]       epoch_count;
  logic [ERR_W-1:0] epoch_err;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   learn_hi_cnt = 0;
  exp_t exp_q[$];

  neuron_train_ctrl #(.N(N), .SEED_CYCLES(8), .SETTLE_CYCLES(2), .MAX_EPOCHS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .learn_en(learn_en), .err_threshold(err_threshold),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_in(smp_in), .smp_expected(smp_expected),
    .smp_last(smp_last), .nrn_trigger(nrn_trigger), .nrn_valid(nrn_valid), .nrn_learn(nrn_learn),
    .nrn_in(nrn_in), .nrn_expected_out(nrn_expected_out), .nrn_out(nrn_out), .busy(busy),
    .done(done), .converged(converged), .epoch_count(epoch_count), .epoch_err(epoch_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (nrn_learn === 1'b1) learn_hi_cnt <= learn_hi_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({busy, done, converged, smp_ready, nrn_trigger, nrn_valid, nrn_learn} !== 7'b0 ||
        epoch_count !== 8'd0 || epoch_err !== 24'd0 || nrn_in !== '0 || nrn_expected_out !== 16'd0) begin
      tests_failed++;
      $display("FAIL %s: flags=%b cnt=%0d err=%0d in=%h exp=%h, required all zero", name,
               {busy, done, converged, smp_ready, nrn_trigger, nrn_valid, nrn_learn},
               epoch_count, epoch_err, nrn_in, nrn_expected_out);
    end
  endtask

  // Raise start (or keep it raised), count SEED triggers until FETCH is reached.
  task automatic start_run(output int trig, output bit valid_seen, output bit reached);
    trig = 0; valid_seen = 0; reached = 0;
    if (start !== 1'b1) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int k = 0; k < 40 && !reached; k++) begin
      @(negedge clk);
      if (smp_ready === 1'b1) reached = 1;
      else begin
        if (nrn_trigger === 1'b1) trig++;
        if (nrn_valid === 1'b1) valid_seen = 1;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_seed(input string name);
    int  trig;
    bit  vs, ok;
    start_run(trig, vs, ok);
    tests_run++;
    if (!ok || trig != 8 || vs) begin
      tests_failed++;
      $display("FAIL %s: reached_fetch=%0d triggers=%0d valid_seen=%0d, required 1/8/0", name, ok, trig, vs);
    end
  endtask

  task automatic feed(input zero2one_t ex, input zero2one_t ov, input logic last, input bit check_hold);
    bit ok;
    zero2one_t [N-1:0] held;
    @(negedge clk);
    for (int i = 0; i < N; i++) smp_in[i] = zero2one_t'($urandom_range(0, 65535));
    held = smp_in;
    smp_expected = ex; smp_last = last; smp_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (smp_ready === 1'b1) begin
        nrn_out = ov;
        @(posedge clk);
        ok = 1;
      end else @(negedge clk);
    end
    @(negedge clk);
    smp_valid = 1'b0;
    if (!ok) begin
      tests_run++; tests_failed++;
      $display("FAIL feed_timeout: no transfer within 100 cycles");
    end else if (check_hold) begin
      tests_run++;
      if (nrn_in !== held || nrn_expected_out !== ex) begin
        tests_failed++;
        $display("FAIL sample_hold: nrn_in=%h exp=%h, required %h/%h", nrn_in, nrn_expected_out, held, ex);
      end
    end
  endtask

  task automatic wait_epoch(input string name);
    exp_t e;
    bit   seen;
    e = exp_q.pop_front();
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (epoch_count === e.cnt) seen = 1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s_count: epoch_count=%0d, required %0d", name, epoch_count, e.cnt);
    end
    tests_run++;
    if (epoch_err !== e.err) begin
      tests_failed++;
      $display("FAIL %s_err: epoch_err=%0d, required %0d", name, epoch_err, e.err);
    end
  endtask

  task automatic wait_done(input string name, input logic exp_conv, input logic [7:0] exp_cnt);
    bit seen;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    tests_run++;
    if (!seen || converged !== exp_conv || busy !== 1'b0 || epoch_count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL %s: done=%0d converged=%0d busy=%0d cnt=%0d, required 1/%0d/0/%0d",
               name, seen, converged, busy, epoch_count, exp_conv, exp_cnt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; learn_en = 1'b1; err_threshold = 24'd0;
    smp_valid = 1'b0; smp_last = 1'b0; smp_expected = 16'd0; nrn_out = 16'd0; smp_in = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_values");
    rst = 1'b0;
    check_seed("seed_after_reset");
  endtask

  task automatic test_converge;
    err_threshold = 24'd0;
    feed(16'd100, 16'd100, 1'b0, 1'b1);
    feed(16'd200, 16'd200, 1'b1, 1'b1);
    exp_q.push_back('{8'd1, 24'd0});
    wait_epoch("converge_epoch");
    wait_done("converge_done", 1'b1, 8'd1);
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || converged !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_done: done=%0d converged=%0d busy=%0d, required 0/1/0", done, converged, busy);
    end
  endtask

  task automatic test_max_epochs;
    int base;
    zero2one_t ex[4];
    zero2one_t ov[4];
    ex = '{16'd50, 16'd0, 16'd65535, 16'd30000};
    ov = '{16'd40, 16'd10, 16'd65525, 16'd30010};
    err_threshold = 24'd0; learn_en = 1'b1;
    base = learn_hi_cnt;
    check_seed("seed_run2");
    tests_run++;
    if (converged !== 1'b0) begin
      tests_failed++;
      $display("FAIL converged_clear: converged=%0d, required 0", converged);
    end
    for (int e = 0; e < 3; e++) begin
      for (int s = 0; s < 4; s++) feed(ex[s], ov[s], (s == 3), 1'b0);
      exp_q.push_back('{8'(e + 1), 24'd40});
      wait_epoch("max_epoch");
    end
    wait_done("max_done", 1'b0, 8'd3);
    repeat (2) @(negedge clk);
    tests_run++;
    if (learn_hi_cnt - base != 12) begin
      tests_failed++;
      $display("FAIL learn_pulses: count=%0d, required 12", learn_hi_cnt - base);
    end
  endtask

  task automatic test_stall;
    zero2one_t [N-1:0] held;
    bit ok;
    err_threshold = 24'd17;
    check_seed("seed_run3");
    feed(16'd10, 16'd0, 1'b0, 1'b1);
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (smp_ready === 1'b1) ok = 1;
    end
    held = nrn_in;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (!ok || smp_ready !== 1'b1 || nrn_trigger !== 1'b0 || nrn_valid !== 1'b0 ||
          busy !== 1'b1 || nrn_in !== held) begin
        tests_failed++;
        $display("FAIL stall_frozen: ready=%0d trig=%0d valid=%0d busy=%0d, required 1/0/0/1",
                 smp_ready, nrn_trigger, nrn_valid, busy);
      end
      @(negedge clk);
    end
    feed(16'd0, 16'd7, 1'b1, 1'b1);
    exp_q.push_back('{8'd1, 24'd17});
    wait_epoch("stall_epoch");
    wait_done("stall_threshold_equal", 1'b1, 8'd1);
  endtask

  task automatic test_saturate;
    err_threshold = 24'd0;
    check_seed("seed_run4");
    for (int s = 0; s < 257; s++) feed(16'd0, 16'd65535, (s == 256), 1'b0);
    exp_q.push_back('{8'd1, 24'hFFFFFF});
    wait_epoch("saturate_epoch");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid;
    err_threshold = 24'd0;
    check_seed("seed_run5");
    feed(16'd100, 16'd91, 1'b0, 1'b0);
    feed(16'd20, 16'd0, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_settle");
    rst = 1'b0;
    check_seed("seed_after_mid_reset");
    feed(16'd5, 16'd5, 1'b1, 1'b1);
    exp_q.push_back('{8'd1, 24'd0});
    wait_epoch("after_reset_epoch");
    wait_done("after_reset_done", 1'b1, 8'd1);
  endtask

  task automatic test_no_learn;
    int base;
    learn_en = 1'b0; err_threshold = 24'd0;
    base = learn_hi_cnt;
    check_seed("seed_run6");
    for (int e = 0; e < 3; e++) begin
      feed(16'd3, 16'd0, 1'b0, 1'b0);
      feed(16'd0, 16'd4, 1'b1, 1'b0);
      exp_q.push_back('{8'(e + 1), 24'd7});
      wait_epoch("no_learn_epoch");
    end
    wait_done("no_learn_done", 1'b0, 8'd3);
    repeat (2) @(negedge clk);
    tests_run++;
    if (learn_hi_cnt != base) begin
      tests_failed++;
      $display("FAIL no_learn_pulses: count=%0d, required 0", learn_hi_cnt - base);
    end
  endtask

  initial begin
    test_reset;
    test_converge;
    test_max_epochs;
    test_stall;
    test_saturate;
    test_reset_mid;
    test_no_learn;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
